// File: rtl/comp_serial.sv
// comp_serial: bit-serial unsigned magnitude comparator.
// Captures two WIDTH-bit operands on an accepted start and walks one bit
// pair per clock, MSB first, then reports registered eq/gt/lt with a
// single-cycle done strobe.
// Optional build macro: COMP_SERIAL_EARLY_EXIT_EN -- when defined, the
// first differing bit pair ends the compare on the same edge; equal
// operands still take the full WIDTH edges.
module comp_serial #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state, r_state_next;
  logic [WIDTH-1:0]   r_a_sh, r_a_sh_next;
  logic [WIDTH-1:0]   r_b_sh, r_b_sh_next;
  logic [CNT_W-1:0]   r_idx, r_idx_next;
  logic               r_decided, r_decided_next;
  logic               r_g, r_g_next;
  logic               r_l, r_l_next;
  logic               r_busy, r_busy_next;
  logic               r_done, r_done_next;
  logic               r_eq, r_eq_next;
  logic               r_gt, r_gt_next;
  logic               r_lt, r_lt_next;

  // Current bit pair under evaluation always sits at the MSB of the shifters.
  logic w_a_bit;
  logic w_b_bit;
  logic w_first_diff;
  logic w_decided_now;
  logic w_g_now;
  logic w_l_now;
  logic w_last_bit;

  assign w_a_bit      = r_a_sh[WIDTH-1];
  assign w_b_bit      = r_b_sh[WIDTH-1];
  // Only the first differing pair (from the MSB down) decides the order.
  assign w_first_diff = ~r_decided & (w_a_bit ^ w_b_bit);
  assign w_decided_now = r_decided | w_first_diff;
  assign w_g_now      = w_first_diff ? (w_a_bit & ~w_b_bit) : r_g;
  assign w_l_now      = w_first_diff ? (~w_a_bit & w_b_bit) : r_l;
  assign w_last_bit   = (r_idx == '0);

  // State and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_g       <= 1'b0;
      r_l       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
    end else begin
      r_state   <= r_state_next;
      r_a_sh    <= r_a_sh_next;
      r_b_sh    <= r_b_sh_next;
      r_idx     <= r_idx_next;
      r_decided <= r_decided_next;
      r_g       <= r_g_next;
      r_l       <= r_l_next;
      r_busy    <= r_busy_next;
      r_done    <= r_done_next;
      r_eq      <= r_eq_next;
      r_gt      <= r_gt_next;
      r_lt      <= r_lt_next;
    end
  end

  // Next-state and next-output logic; everything holds unless a state says otherwise.
  always_comb begin
    r_state_next   = r_state;
    r_a_sh_next    = r_a_sh;
    r_b_sh_next    = r_b_sh;
    r_idx_next     = r_idx;
    r_decided_next = r_decided;
    r_g_next       = r_g;
    r_l_next       = r_l;
    r_busy_next    = r_busy;
    r_done_next    = 1'b0;
    r_eq_next      = r_eq;
    r_gt_next      = r_gt;
    r_lt_next      = r_lt;

    case (r_state)
      IDLE: begin
        r_busy_next = 1'b0;
        if (start) begin
          r_a_sh_next    = a;
          r_b_sh_next    = b;
          r_idx_next     = CNT_W'(WIDTH - 1);
          r_decided_next = 1'b0;
          r_g_next       = 1'b0;
          r_l_next       = 1'b0;
          r_eq_next      = 1'b0;
          r_gt_next      = 1'b0;
          r_lt_next      = 1'b0;
          r_busy_next    = 1'b1;
          r_state_next   = SHIFT;
        end
      end

      SHIFT: begin
        r_a_sh_next    = {r_a_sh[WIDTH-2:0], 1'b0};
        r_b_sh_next    = {r_b_sh[WIDTH-2:0], 1'b0};
        r_idx_next     = r_idx - CNT_W'(1);
        r_decided_next = w_decided_now;
        r_g_next       = w_g_now;
        r_l_next       = w_l_now;
`ifdef COMP_SERIAL_EARLY_EXIT_EN
        // A differing pair settles the order; freeze the shifters and counter.
        if (w_first_diff || w_last_bit) begin
          r_a_sh_next  = r_a_sh;
          r_b_sh_next  = r_b_sh;
          r_idx_next   = r_idx;
          r_eq_next    = ~w_decided_now;
          r_gt_next    = w_g_now;
          r_lt_next    = w_l_now;
          r_done_next  = 1'b1;
          r_busy_next  = 1'b0;
          r_state_next = DONE;
        end
`else
        // Fixed latency: publish the result only after the LSB pair.
        if (w_last_bit) begin
          r_eq_next    = ~w_decided_now;
          r_gt_next    = w_g_now;
          r_lt_next    = w_l_now;
          r_done_next  = 1'b1;
          r_busy_next  = 1'b0;
          r_state_next = DONE;
        end
`endif
      end

      DONE: begin
        // One-cycle result strobe; start is deliberately not sampled here.
        r_busy_next  = 1'b0;
        r_state_next = IDLE;
      end

      default: begin
        r_busy_next  = 1'b0;
        r_state_next = IDLE;
      end
    endcase
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule
